// File: rtl/run_ctrl_pkg.sv
// Shared run-controller encodings: FSM states and the reason a run ended.
// No logic of its own; the end-cause helper decodes the registered flags.
package run_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RESET = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HALT    = 2'd1,
    CAUSE_STALL   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } end_cause_e;

  // A finished run with neither flag set can only have ended on halt.
  function automatic end_cause_e cause_of(input logic dn, input logic to, input logic st);
    if (!dn) return CAUSE_NONE;
    if (st)  return CAUSE_STALL;
    if (to)  return CAUSE_TIMEOUT;
    return CAUSE_HALT;
  endfunction

endpackage

// File: rtl/run_ctrl_stall_detect.sv
// Self-loop detector: hit flags the commit that repeats the previous PC for the
// STALL_LIMIT-th consecutive time; hit is combinational, state updates next edge, no backpressure.
module stall_detect
  import run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            commit,
  input  logic [PC_W-1:0] pc,
  output logic            hit
);

  logic [PC_W-1:0]  prev_pc;
  logic             prev_vld;
  logic [CNT_W-1:0] stall_cnt;
  logic             same;

  assign same = prev_vld && (pc == prev_pc);
  assign hit  = commit && same && (stall_cnt == CNT_W'(STALL_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc   <= '0;
      prev_vld  <= 1'b0;
      stall_cnt <= '0;
    end else if (clr) begin
      prev_vld  <= 1'b0;
      stall_cnt <= '0;
    end else if (commit) begin
      stall_cnt <= same ? stall_cnt + 1'b1 : '0;
      prev_pc   <= pc;
      prev_vld  <= 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the CPU in reset for RST_CYCLES, counts cycles/commits, stops on
// halt, self-loop or timeout. All outputs registered (1-cycle); no backpressure, start is level-sampled.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = 2,
  parameter int TIMEOUT     = 50,
  parameter int STALL_LIMIT = 4,
  parameter int CNT_W       = 16,
  parameter int PC_W        = 32
) (
  input  logic             CLK,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             commit,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             stalled,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  logic [1:0]       state;
  logic [CNT_W-1:0] rst_cnt;
  logic             launch;
  logic             run_commit;
  logic             hit;

  assign launch     = ((state == IDLE) || (state == DONE)) && start;
  assign run_commit = (state == RUN) && commit;

  stall_detect #(
    .PC_W        (PC_W),
    .CNT_W       (CNT_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk    (CLK),
    .rst_n  (Rst_n),
    .clr    (launch),
    .commit (run_commit),
    .pc     (pc),
    .hit    (hit)
  );

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      rst_cnt <= '0;
      cpu_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      stalled <= 1'b0;
      cycles  <= '0;
      instret <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RESET;
            rst_cnt <= '0;
            cpu_rst <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            timeout <= 1'b0;
            stalled <= 1'b0;
            cycles  <= '0;
            instret <= '0;
          end
        end
        RESET: begin
          rst_cnt <= rst_cnt + 1'b1;
          if (rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end
        end
        RUN: begin
          // The exiting cycle is still counted, commit included.
          cycles <= cycles + 1'b1;
          if (commit) instret <= instret + 1'b1;
          if (halt || hit || (cycles == CNT_W'(TIMEOUT - 1))) begin
            state   <= DONE;
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            stalled <= !halt && hit;
            timeout <= !halt && !hit;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed runs push expected end records; monitors pop and compare on done.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        Rst_n, start, commit, halt;
  logic [31:0] pc;
  logic        cpu_rst, busy, done, timeout, stalled;
  logic [15:0] cycles, instret;

  logic        start2, commit2, halt2;
  logic [31:0] pc2;
  logic        cpu_rst2, busy2, done2, timeout2, stalled2;
  logic [15:0] cycles2, instret2;

  run_ctrl u_dut (
    .CLK(clk), .Rst_n(Rst_n), .start(start), .commit(commit), .pc(pc), .halt(halt),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .timeout(timeout), .stalled(stalled),
    .cycles(cycles), .instret(instret)
  );

  run_ctrl #(.RST_CYCLES(1), .TIMEOUT(3)) u_small (
    .CLK(clk), .Rst_n(Rst_n), .start(start2), .commit(commit2), .pc(pc2), .halt(halt2),
    .cpu_rst(cpu_rst2), .busy(busy2), .done(done2), .timeout(timeout2), .stalled(stalled2),
    .cycles(cycles2), .instret(instret2)
  );

  typedef struct {
    end_cause_e cause;
    int         cyc;
    int         ins;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the default instance
  initial begin : mon_a
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev) begin
        if (sb_a.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL a_unexpected_done: got done=1 expected no run end");
        end else begin
          ea = sb_a.pop_front();
          check("a_cause",   cause_of(done, timeout, stalled), ea.cause);
          check("a_cycles",  cycles,  ea.cyc);
          check("a_instret", instret, ea.ins);
          check("a_cpu_rst", cpu_rst, 1);
          check("a_busy",    busy,    0);
        end
      end
      prev = done;
    end
  end

  // Monitor for the short-parameter instance
  initial begin : mon_b
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done2 && !prev) begin
        if (sb_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL b_unexpected_done: got done=1 expected no run end");
        end else begin
          eb = sb_b.pop_front();
          check("b_cause",   cause_of(done2, timeout2, stalled2), eb.cause);
          check("b_cycles",  cycles2,  eb.cyc);
          check("b_instret", instret2, eb.ins);
          check("b_cpu_rst", cpu_rst2, 1);
        end
      end
      prev = done2;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no end of test expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  // Start a run on the default instance and follow it into RUN.
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_busy",    busy,    1);
    check("launch_done",    done,    0);
    check("launch_cycles",  cycles,  0);
    check("launch_instret", instret, 0);
    check("launch_flags",   {timeout, stalled}, 0);
    tick();
    check("rst_hold",    cpu_rst, 1);
    tick();
    check("rst_release", cpu_rst, 0);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: got no done expected done within %0d cycles", budget);
    end
  endtask

  int n;
  int lows;
  int pcs [8];

  initial begin
    Rst_n = 1'b0; start = 1'b0; commit = 1'b0; halt = 1'b0; pc = '0;
    start2 = 1'b0; commit2 = 1'b0; halt2 = 1'b0; pc2 = '0;
    pcs = '{0, 4, 8, 12, 12, 12, 12, 12};

    // Power-on reset
    repeat (2) tick();
    check("por_cpu_rst", cpu_rst, 1);
    check("por_busy",    busy,    0);
    check("por_cycles",  cycles,  0);
    check("por_done",    done,    0);
    Rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy",    busy,    0);
    check("idle_cpu_rst", cpu_rst, 1);

    // Plain timeout run
    sb_a.push_back('{CAUSE_TIMEOUT, 50, 0});
    start_run();
    wait_done(200, n);
    check("timeout_latency", n, 50);
    repeat (2) tick();

    // Self-loop at PC 12
    sb_a.push_back('{CAUSE_STALL, 8, 8});
    start_run();
    for (int i = 0; i < 8; i++) begin
      commit = 1'b1;
      pc = pcs[i];
      tick();
      if (i < 7) check("stall_not_early", done, 0);
    end
    commit = 1'b0;
    check("stall_done", done, 1);
    repeat (2) tick();

    // Halt on the same cycle as the timeout
    sb_a.push_back('{CAUSE_HALT, 50, 3});
    start_run();
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1;
      pc = 32'd100 + 32'(4 * i);
      tick();
    end
    commit = 1'b0;
    repeat (46) tick();
    check("halt_pre_cycles", cycles, 49);
    check("halt_pre_done",   done,   0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("halt_done",   done,   1);
    check("halt_cycles", cycles, 50);
    repeat (2) tick();

    // Async reset mid-run with start held high
    start_run();
    start = 1'b1;
    repeat (17) tick();
    check("midrun_cycles", cycles, 17);
    check("midrun_busy",   busy,   1);
    #1 Rst_n = 1'b0;
    #1;
    check("arst_cpu_rst", cpu_rst, 1);
    check("arst_busy",    busy,    0);
    check("arst_cycles",  cycles,  0);
    check("arst_instret", instret, 0);
    check("arst_done",    done,    0);
    start = 1'b0;
    @(negedge clk);
    Rst_n = 1'b1;
    tick();
    check("post_arst_busy", busy, 0);

    // Short instance: one reset cycle, three-cycle limit
    sb_b.push_back('{CAUSE_TIMEOUT, 3, 0});
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lows = 0;
    repeat (6) begin
      tick();
      if (!cpu_rst2) lows++;
    end
    check("small_low_cycles", lows,  3);
    check("small_done",       done2, 1);

    repeat (2) tick();
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesizable run controller that replaces the fixed-delay reset pulse and fixed-time stop of the CPU bench. It generates the CPU reset with a configurable length, counts cycles and retired instructions, and ends a run on an explicit halt, a self-loop, or a timeout. It sits between the bench (or a board start button) and `CPU`, and drives `CPU.Rst`.

## Interface
- `RST_CYCLES`, 2: cycles `cpu_rst` is held high after `start`; must be ≥1.
- `TIMEOUT`, 50: run-cycle limit; must be < 2^`CNT_W`.
- `STALL_LIMIT`, 4: consecutive commits at an unchanged PC that count as a halt; must be ≥1.
- `CNT_W`, 16: width of the counters.
- `PC_W`, 32: PC width.

- `CLK` in 1: single clock, rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled run request.
- `commit` in 1: the CPU retired one instruction this cycle.
- `pc` in `PC_W`: PC of the retiring instruction; valid when `commit`=1.
- `halt` in 1: explicit halt from the CPU (e.g. `break`).
- `cpu_rst` out 1: active-high reset to `CPU`.
- `busy` out 1: state is RESET or RUN.
- `done` out 1: state is DONE.
- `timeout` out 1: the run ended on the cycle limit.
- `stalled` out 1: the run ended on self-loop detection.
- `cycles` out `CNT_W`: RUN cycles elapsed.
- `instret` out `CNT_W`: commits seen in RUN.

## Operation
- All outputs are registered. Reset values: state IDLE, `cpu_rst`=1, all other outputs 0, internal `rst_cnt`, `stall_cnt`, `prev_pc` and `prev_vld` all 0.
- IDLE: `cpu_rst`=1. `start`=1 moves to RESET and sets `rst_cnt`=0.
- RESET: `cpu_rst`=1. `rst_cnt` increments each cycle. Once `RST_CYCLES` cycles have passed, move to RUN. On entry to RESET, clear `cycles`, `instret`, `timeout`, `stalled`, `stall_cnt` and `prev_vld`.
- RUN: `cpu_rst`=0. `cycles` increments every cycle. `instret` increments on `commit`.
  - On `commit` with `prev_vld`=1 and `pc`==`prev_pc`, increment `stall_cnt`; otherwise clear it. Each commit loads `prev_pc`=`pc` and sets `prev_vld`=1.
  - Exit conditions, in priority order (highest first):
    - `halt`=1: move to DONE.
    - The commit that would make `stall_cnt`==`STALL_LIMIT`: move to DONE with `stalled`=1.
    - `cycles`==`TIMEOUT`-1 while incrementing: move to DONE with `timeout`=1.
  - The cycle that causes the exit is still counted, including any commit in that cycle.
- DONE: `cpu_rst`=1 so the CPU is frozen. Counters and flags hold. `start`=1 moves to RESET and begins a new run.
- `start` is ignored in RESET and RUN. `commit` and `halt` are ignored outside RUN.
- Asserting `Rst_n` at any point, including mid-run, forces the reset values immediately without waiting for a clock edge.
- Counters never wrap: the `TIMEOUT` bound guarantees an exit before wrap-around.

## Timing
- If `start` is sampled high at edge t, `busy`=1 from t. `cpu_rst` falls at edge t+`RST_CYCLES`, which is the first RUN cycle.
- `cycles` reads k after k RUN edges.
- `done` rises at the edge that samples the exit condition. The flags and counters are final in that same cycle.
- With no halt or stall, `done` rises `TIMEOUT` edges after `cpu_rst` falls, and `cycles`=`TIMEOUT`.
- `halt` and a timeout in the same cycle: `timeout`=0, `stalled`=0.
- A stall and a timeout in the same cycle: `stalled`=1, `timeout`=0.

## Structure
- Shared package `run_ctrl_pkg` holds:
  - The state encoding, IDLE=2'd0, RESET=2'd1, RUN=2'd2, DONE=2'd3.
  - An end-cause encoding, NONE/HALT/STALL/TIMEOUT, which the bench reuses for reporting.
- One natural sub-module, `stall_detect`: the `prev_pc`/`stall_cnt` comparator, with a `hit` output.
- The FSM and counters stay in `run_ctrl`.
- `test.v`-style benches instantiate `run_ctrl` and finish on `done` rather than using a fixed delay.

## Test plan
- Power-on with `Rst_n` low for 2 cycles, then high → `cpu_rst`=1, `busy`=0, `cycles`=0; remains IDLE while `start`=0.
- `start` pulse with defaults, no commits → `cpu_rst` high for 2 cycles, then low. After 50 cycles: `done`=1, `timeout`=1, `cycles`=50, `instret`=0, `cpu_rst`=1.
- Commits at PC 0,4,8,12, then PC 12 four more times → `done`=1 on the 4th repeat, `stalled`=1, `instret`=8, `timeout`=0.
- `halt` and cycle 50 in the same cycle → `done`=1, `timeout`=0, `stalled`=0, `cycles`=50. A second `start` clears all counters and flags on RESET entry.
- `Rst_n` pulsed low mid-RUN at `cycles`=17 → outputs return to reset values asynchronously; a `start` held high during RUN has no effect.
- `RST_CYCLES`=1, `TIMEOUT`=3 → `cpu_rst` low for exactly 3 cycles, then `done`=1 with `cycles`=3.
